// File: rtl/branch_pkg.sv
// Shared definitions for the branch predict unit: branch condition codes,
// the 2-bit saturating counter state and the counter reset value.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    localparam cnt_t CNT_RST = WNT;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation; flags the two unused funct3 codes.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rd1_i,
    input  logic [DW-1:0] rd2_i,
    input  logic [2:0]    funct3_i,
    output logic          taken_o,
    output logic          illegal_o
);

    logic signed [DW-1:0] rd1_s;
    logic signed [DW-1:0] rd2_s;

    assign rd1_s = rd1_i;
    assign rd2_s = rd2_i;

    // Decode the condition and compare the operands
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = (rd1_i == rd2_i);
            F3_BNE:  taken_o = (rd1_i != rd2_i);
            F3_BLT:  taken_o = (rd1_s <  rd2_s);
            F3_BGE:  taken_o = (rd1_s >= rd2_s);
            F3_BLTU: taken_o = (rd1_i <  rd2_i);
            F3_BGEU: taken_o = (rd1_i >= rd2_i);
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predict unit: 2-bit saturating counter table indexed by pc[IDX_W+1:2],
// zero-latency prediction and a one-cycle registered resolve result.
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int DW    = 32,
    parameter int PC_W  = 32,
    parameter int IDX_W = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [PC_W-1:0] pred_pc_i,
    output logic            pred_taken_o,
    input  logic            res_valid_i,
    input  logic [PC_W-1:0] res_pc_i,
    input  logic [DW-1:0]   rd1_i,
    input  logic [DW-1:0]   rd2_i,
    input  logic [2:0]      funct3_i,
    input  logic            res_pred_i,
    output logic            out_valid_o,
    output logic            branch_o,
    output logic            mispredict_o,
    output logic            illegal_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]     stat_branches_o,
    output logic [31:0]     stat_mispred_o
`endif
);

    localparam int ENTRIES = 1 << IDX_W;

    // Move a counter one step toward the outcome, clamping at ST and SNT
    function automatic cnt_t sat_update(input cnt_t cur, input logic taken);
        cnt_t nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = cnt_t'(cur + 2'd1);
        end else begin
            if (cur != SNT) nxt = cnt_t'(cur - 2'd1);
        end
        return nxt;
    endfunction

    cnt_t             table_q [ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] res_idx;
    logic             cmp_taken;
    logic             cmp_illegal;
    logic             upd_en;
    logic             mis_now;
    logic             vld_p1;
    logic             branch_p1;
    logic             mis_p1;
    logic             ill_p1;
    logic             pc_unused;

    assign pred_idx = pred_pc_i[IDX_W+1:2];
    assign res_idx  = res_pc_i[IDX_W+1:2];
    assign pc_unused = ^{pred_pc_i[PC_W-1:IDX_W+2], pred_pc_i[1:0],
                         res_pc_i[PC_W-1:IDX_W+2], res_pc_i[1:0]};

    branch_cmp #(
        .DW(DW)
    ) u_cmp (
        .rd1_i     (rd1_i),
        .rd2_i     (rd2_i),
        .funct3_i  (funct3_i),
        .taken_o   (cmp_taken),
        .illegal_o (cmp_illegal)
    );

    assign upd_en  = res_valid_i && !cmp_illegal;
    assign mis_now = cmp_taken != res_pred_i;

    // Prediction reads the stored counter directly; a same-cycle update is not bypassed
    assign pred_taken_o = table_q[pred_idx][1];

    // Counter table: all entries WNT on reset, one saturating step per legal resolve
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) table_q[i] <= CNT_RST;
        end else if (upd_en) begin
            table_q[res_idx] <= sat_update(table_q[res_idx], cmp_taken);
        end
    end

    // ---- stage p1: registered resolve result, zeroed when no request ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1    <= 1'b0;
            branch_p1 <= 1'b0;
            mis_p1    <= 1'b0;
            ill_p1    <= 1'b0;
        end else begin
            vld_p1    <= res_valid_i;
            branch_p1 <= upd_en && cmp_taken;
            mis_p1    <= upd_en && mis_now;
            ill_p1    <= res_valid_i && cmp_illegal;
        end
    end

    assign out_valid_o  = vld_p1;
    assign branch_o     = branch_p1;
    assign mispredict_o = mis_p1;
    assign illegal_o    = ill_p1;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_br_q;
    logic [31:0] stat_mis_q;

    // Free-running event counters; natural 32-bit wrap
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stat_br_q  <= 32'd0;
            stat_mis_q <= 32'd0;
        end else if (upd_en) begin
            stat_br_q <= stat_br_q + 32'd1;
            if (mis_now) stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign stat_branches_o = stat_br_q;
    assign stat_mispred_o  = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: vector table plus hand-written sequences.
module tb_branch_predict_unit;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] pred_pc_i;
    logic        pred_taken_o;
    logic        res_valid_i;
    logic [31:0] res_pc_i;
    logic [31:0] rd1_i;
    logic [31:0] rd2_i;
    logic [2:0]  funct3_i;
    logic        res_pred_i;
    logic        out_valid_o;
    logic        branch_o;
    logic        mispredict_o;
    logic        illegal_o;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispred_o;
`endif

    int total;
    int bad;

    branch_predict_unit #(.DW(32), .PC_W(32), .IDX_W(4)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .pred_pc_i    (pred_pc_i),
        .pred_taken_o (pred_taken_o),
        .res_valid_i  (res_valid_i),
        .res_pc_i     (res_pc_i),
        .rd1_i        (rd1_i),
        .rd2_i        (rd2_i),
        .funct3_i     (funct3_i),
        .res_pred_i   (res_pred_i),
        .out_valid_o  (out_valid_o),
        .branch_o     (branch_o),
        .mispredict_o (mispredict_o),
        .illegal_o    (illegal_o)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches_o (stat_branches_o),
        .stat_mispred_o  (stat_mispred_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        pred;
        logic        exp_br;
        logic        exp_mis;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic p);
        res_valid_i = v;
        res_pc_i    = pc;
        funct3_i    = f3;
        rd1_i       = a;
        rd2_i       = b;
        res_pred_i  = p;
    endtask

    task automatic check_out(input string name, input logic v, input logic br,
                             input logic mis, input logic ill);
        check({name, ".valid"}, {31'd0, out_valid_o}, {31'd0, v});
        check({name, ".branch"}, {31'd0, branch_o}, {31'd0, br});
        check({name, ".mispredict"}, {31'd0, mispredict_o}, {31'd0, mis});
        check({name, ".illegal"}, {31'd0, illegal_o}, {31'd0, ill});
    endtask

    task automatic check_pred(input string name, input logic [31:0] pc, input logic exp);
        pred_pc_i = pc;
        #1;
        check(name, {31'd0, pred_taken_o}, {31'd0, exp});
    endtask

    logic seq_taken [7];
    logic seq_pred  [7];
    logic seq_mis   [7];
    logic seq_after [7];
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_before;
`endif

    initial begin
        total = 0;
        bad   = 0;

        // {funct3, rd1, rd2, res_pred, branch, mispredict, illegal}
        vecs[0]  = '{3'b110, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'b101, 32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b000, 32'h00000005, 32'h00000005, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{3'b000, 32'h00000005, 32'h00000006, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 32'h00000005, 32'h00000006, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b001, 32'h00000007, 32'h00000007, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{3'b100, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 32'h00000000, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{3'b101, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b111, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{3'b111, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{3'b011, 32'h00000005, 32'h00000005, 1'b1, 1'b0, 1'b0, 1'b1};

        // Saturation run at PC 0x20: five taken, then two not-taken
        seq_taken = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        seq_pred  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        seq_mis   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        seq_after = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst_ni    = 1'b0;
        pred_pc_i = 32'h0;
        drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        #1;
        check_out("reset_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        rst_ni = 1'b1;
        step();
        check_out("after_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_pred("reset_pred_0x10", 32'h10, 1'b0);
        for (int i = 0; i < 16; i++) check_pred("reset_pred_all", i << 2, 1'b0);

        // blt -1 < 1: taken, mispredicted; index 4 WNT -> WT
        pred_pc_i = 32'h10;
        drive(1'b1, 32'h10, 3'b100, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        step();
        drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        check_out("blt_signed", 1'b1, 1'b1, 1'b1, 1'b0);
        check_pred("blt_pred_0x10", 32'h10, 1'b1);

        // Vector table, back-to-back at PC 0x3C
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, 32'h3C, vecs[i].f3, vecs[i].rd1, vecs[i].rd2, vecs[i].pred);
            step();
            check_out($sformatf("vec%0d", i), 1'b1, vecs[i].exp_br, vecs[i].exp_mis, vecs[i].exp_ill);
        end
        drive(1'b0, 32'h3C, 3'b000, 32'h1, 32'h1, 1'b0);
        step();
        check_out("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Saturation at index 8
        pred_pc_i = 32'h20;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h20, 3'b000, 32'h9, seq_taken[i] ? 32'h9 : 32'hA, seq_pred[i]);
            step();
            check_out($sformatf("sat%0d", i), 1'b1, seq_taken[i], seq_mis[i], 1'b0);
            check_pred($sformatf("sat_pred%0d", i), 32'h20, seq_after[i]);
        end

        // Illegal funct3 on index 2 must leave the WNT counter alone
`ifdef BRANCH_STATS_EN
        stat_before = stat_branches_o;
`endif
        drive(1'b1, 32'h08, 3'b010, 32'h3, 32'h3, 1'b0);
        step();
        drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        check_out("illegal010", 1'b1, 1'b0, 1'b0, 1'b1);
        check_pred("illegal_pred_0x08", 32'h08, 1'b0);
`ifdef BRANCH_STATS_EN
        check("illegal_stat", stat_branches_o, stat_before);
`endif

        // Same-index predict and update: old value before the edge, new after
        pred_pc_i = 32'h0C;
        drive(1'b1, 32'h0C, 3'b001, 32'h1, 32'h2, 1'b0);
        #1;
        check("same_idx_old", {31'd0, pred_taken_o}, 32'd0);
        step();
        check("same_idx_new", {31'd0, pred_taken_o}, 32'd1);
        check_out("same_idx_out", 1'b1, 1'b1, 1'b1, 1'b0);

        // Mid-stream reset with a request held through it
        drive(1'b1, 32'h10, 3'b000, 32'h4, 32'h4, 1'b1);
        step();
        check_out("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0);
        rst_ni = 1'b0;
        #1;
        check_out("mid_rst_async", 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check_out("mid_rst_hold", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_ni = 1'b1;
        drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        step();
        check_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        check_pred("post_rst_0x10", 32'h10, 1'b0);
        check_pred("post_rst_0x0C", 32'h0C, 1'b0);
        check_pred("post_rst_0x20", 32'h20, 1'b0);
        check_pred("post_rst_0x3C", 32'h3C, 1'b0);

        // One taken after reset proves the entry restarted at WNT
        drive(1'b1, 32'h0C, 3'b000, 32'h1, 32'h1, 1'b0);
        step();
        drive(1'b0, 32'h0, 3'b000, 32'h0, 32'h0, 1'b0);
        check_out("post_rst_req", 1'b1, 1'b1, 1'b1, 1'b0);
        check_pred("post_rst_wt", 32'h0C, 1'b1);
        step();
        check_out("final_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter DW, default 32, operand width.
REQ-002 SHALL have parameter PC_W, default 32, program-counter width.
REQ-003 SHALL have parameter IDX_W, default 4, history table index width (2^IDX_W entries).
REQ-004 SHALL have one clock and an asynchronous active-low reset: clk_i  input  1  clock; rst_ni  input  1  async reset, active low.
REQ-005 SHALL have the following ports:
- pred_pc_i  input  PC_W  fetch PC to predict.
- pred_taken_o  output  1  prediction for pred_pc_i.
- res_valid_i  input  1  resolve request valid.
- res_pc_i  input  PC_W  PC of the branch being resolved.
- rd1_i, rd2_i  input  DW  register operands.
- funct3_i  input  3  branch condition.
- res_pred_i  input  1  prediction originally issued for this branch.
- out_valid_o  output  1  registered result valid.
- branch_o  output  1  actual outcome (1 = taken).
- mispredict_o  output  1  outcome differs from res_pred_i.
- illegal_o  output  1  funct3_i is 010 or 011.

Function
REQ-006 SHALL evaluate funct3 as follows: 000 beq, 001 bne, 100 blt (signed), 101 bge (signed), 110 bltu, 111 bgeu; signed compares correct for any DW, including operands of differing sign.
REQ-007 SHALL hold a table of 2^IDX_W 2-bit saturating counters with states SNT=00, WNT=01, WT=10, ST=11.
REQ-008 SHALL index the table by pc[IDX_W+1:2] for both prediction and update.
REQ-009 SHALL drive pred_taken_o combinationally as the MSB of the indexed counter (zero latency).
REQ-010 SHALL register out_valid_o, branch_o, mispredict_o and illegal_o one cycle after res_valid_i=1 is sampled; out_valid_o=0 in cycles without a request.
REQ-011 SHALL hold branch_o, mispredict_o and illegal_o at 0 whenever out_valid_o=0.
REQ-012 SHALL, on a valid legal resolve, update the indexed counter on the same clock edge: increment if taken, decrement if not taken, saturating at ST and SNT.
REQ-013 SHALL, on an illegal funct3, give branch_o=0, mispredict_o=0, illegal_o=1, and leave the table unchanged.
REQ-014 SHALL, when predict and update hit the same index in one cycle, drive pred_taken_o from the pre-update value (no bypass).
REQ-015 SHALL accept back-to-back resolves every cycle, including repeated updates to the same index, with each update seeing the previous one.

Reset
REQ-016 SHALL, on rst_ni low, immediately clear out_valid_o, branch_o, mispredict_o and illegal_o, and set every counter to WNT.
REQ-017 SHALL discard a resolve sampled in the cycle reset asserts; no output pulse and no counter change after reset release.
REQ-018 SHALL treat reset release as synchronous to clk_i; the first request is accepted on the first rising edge with rst_ni high.

Configuration
REQ-019 SHALL, with BRANCH_STATS_EN defined, add outputs stat_branches_o (32, count of legal resolves) and stat_mispred_o (32, count of mispredicts), both reset to 0 and wrapping from 0xFFFFFFFF to 0.
REQ-020 SHALL, without BRANCH_STATS_EN, omit those ports and counters entirely, with otherwise identical behaviour.

Structure
REQ-021 SHALL take the funct3 condition constants, the 2-bit counter state typedef and the reset state constant (WNT) from shared package branch_pkg.
REQ-022 SHALL place the condition evaluation (REQ-006) in combinational sub-module branch_cmp, instantiated once.

Verification
REQ-023 SHALL cover: reset, then pred_pc_i=0x00000010 -> pred_taken_o=0; all counters WNT.
REQ-024 SHALL cover: blt with rd1=0xFFFFFFFF, rd2=0x00000001, res_pred=0 -> next cycle branch_o=1, mispredict_o=1; index 4 goes WNT->WT; pred_taken_o=1 for PC 0x10.
REQ-025 SHALL cover: bltu with the same operands -> branch_o=0; bge with rd1=rd2=0x80000000 -> branch_o=1.
REQ-026 SHALL cover: four consecutive taken beq at PC 0x20 -> counter saturates at ST; a fifth keeps ST; one not-taken -> WT.
REQ-027 SHALL cover: funct3=010 with res_valid_i=1 -> illegal_o=1, branch_o=0, counter unchanged, stat_branches_o unchanged.
REQ-028 SHALL cover: resolve to index 3 while pred_pc_i indexes 3 in the same cycle -> old prediction shown; new value one cycle later; rst_ni pulsed mid-stream -> outputs 0 at once, counters WNT.
